// File: rtl/down_counter_load_if.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_load_if
//  Description : Control/status bundle for the loadable down counter.
//                The slave side is the counter; the master side drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface down_counter_load_if #(
    parameter int WIDTH = 4
);
    logic             i_en;
    logic             i_load;
    logic [WIDTH-1:0] i_din;
    logic             i_auto_reload;
    logic [WIDTH-1:0] o_q;
    logic             o_busy;
    logic             o_tc;
    logic             o_done;

    modport master (
        output i_en, i_load, i_din, i_auto_reload,
        input  o_q, o_busy, o_tc, o_done
    );

    modport slave (
        input  i_en, i_load, i_din, i_auto_reload,
        output o_q, o_busy, o_tc, o_done
    );
endinterface
`default_nettype wire

// File: rtl/down_counter_load.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_load
//  Description : Loadable WIDTH-bit countdown timer. Counts the loaded start
//                value down to zero one step per enabled clock, pulses done
//                when zero is reached, then either stops (one-shot) or
//                reloads the start value and repeats (auto-reload).
//  Revision    : 1.0 - initial release
// ============================================================================
module down_counter_load #(
    parameter int WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    down_counter_load_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload_val;
    logic             r_done;

    // Counter state machine: load beats enable, enable beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_q          <= '0;
            r_reload_val <= '0;
            r_done       <= 1'b0;
        end else if (bus.i_load) begin
            // A zero start value leaves nothing to count, so stay idle.
            r_q          <= bus.i_din;
            r_reload_val <= bus.i_din;
            r_done       <= 1'b0;
            r_state      <= (bus.i_din != '0) ? S_RUN : S_IDLE;
        end else begin
            // done is a single-cycle pulse; it only rises on the 1->0 step.
            r_done <= 1'b0;
            if (r_state == S_RUN && bus.i_en) begin
                if (r_q > c_ONE) begin
                    r_q <= r_q - c_ONE;
                end else if (r_q == c_ONE) begin
                    r_q    <= '0;
                    r_done <= 1'b1;
                end else if (bus.i_auto_reload) begin
                    // Zero decision edge: restart the period.
                    r_q <= r_reload_val;
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign bus.o_q    = r_q;
    assign bus.o_busy = (r_state == S_RUN);
    assign bus.o_tc   = (r_q == '0);
    assign bus.o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_down_counter_load.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_counter_load
//  Description : Self-checking bench for down_counter_load (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_load;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    down_counter_load_if #(.WIDTH(WIDTH)) bus ();

    down_counter_load #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: remaining count, start value, whether a countdown is live,
    // and whether the previous edge finished a countdown.
    int m_count;
    int m_start;
    bit m_live;
    bit m_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_start = 0;
        m_live  = 0;
        m_done  = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit ld, input int din, input bit en, input bit ar);
        m_done = 0;
        if (ld) begin
            m_count = din;
            m_start = din;
            m_live  = (din != 0);
        end else if (m_live && en) begin
            if (m_count == 0) begin
                if (ar) m_count = m_start;
                else    m_live  = 0;
            end else begin
                m_count = m_count - 1;
                m_done  = (m_count == 0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".q"},    32'(bus.o_q),    32'(m_count));
        check_val({tag, ".busy"}, 32'(bus.o_busy), 32'(m_live));
        check_val({tag, ".tc"},   32'(bus.o_tc),   32'(m_count == 0));
        check_val({tag, ".done"}, 32'(bus.o_done), 32'(m_done));
    endtask

    // Apply inputs, take one edge, then compare just after it.
    task automatic step(input string tag, input bit ld, input int din, input bit en, input bit ar);
        bus.i_load        = ld;
        bus.i_din         = WIDTH'(din);
        bus.i_en          = en;
        bus.i_auto_reload = ar;
        @(posedge clk);
        model_edge(ld, din, en, ar);
        #1;
        check_all(tag);
    endtask

    initial begin
        int edges;
        int n_done;

        bus.i_en          = 1'b0;
        bus.i_load        = 1'b0;
        bus.i_din         = '0;
        bus.i_auto_reload = 1'b0;
        rst_n             = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // One-shot countdown from 3: 3,2,1,0 then busy falls.
        step("os_load", 1, 3, 0, 0);
        check_val("os_q_start", 32'(bus.o_q), 32'd3);
        for (int i = 0; i < 5; i++) step("os_run", 0, 0, 1, 0);
        check_val("os_busy_end", 32'(bus.o_busy), 32'd0);

        // Enable gating with a stall straight after done.
        step("gate_load", 1, 4, 0, 0);
        step("gate", 0, 0, 1, 0);
        step("gate", 0, 0, 0, 0);
        step("gate", 0, 0, 0, 0);
        step("gate", 0, 0, 1, 0);
        step("gate", 0, 0, 1, 0);
        step("gate", 0, 0, 1, 0);
        step("gate_stall", 0, 0, 0, 0);
        step("gate_stall", 0, 0, 0, 0);

        // Auto-reload from 2 for 9 edges: three done pulses.
        step("ar_load", 1, 2, 0, 1);
        n_done = 0;
        for (int i = 0; i < 9; i++) begin
            step("ar_run", 0, 0, 1, 1);
            if (bus.o_done) n_done++;
        end
        check_val("ar_q_end", 32'(bus.o_q), 32'd2);
        check_val("ar_pulses", 32'(n_done), 32'd3);

        // Load beats a done-producing decrement; zero load stays idle.
        step("pri_load", 1, 1, 0, 0);
        step("pri_over", 1, 7, 1, 0);
        check_val("pri_q", 32'(bus.o_q), 32'd7);
        step("zero_load", 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("zero_hold", 0, 0, 1, 1);

        // Maximum start value: exactly 2^WIDTH-1 enabled edges to zero.
        step("max_load", 1, 15, 0, 0);
        edges = 0;
        while (bus.o_q != '0 && edges < 40) begin
            step("max_run", 0, 0, 1, 0);
            edges++;
        end
        check_val("max_edges", 32'(edges), 32'd15);
        for (int i = 0; i < 3; i++) step("max_after", 0, 0, 1, 0);

        // Async reset mid-run with Q=5 clears outputs before the next edge.
        step("rst_load", 1, 8, 0, 0);
        for (int i = 0; i < 3; i++) step("rst_pre", 0, 0, 1, 0);
        check_val("rst_q_pre", 32'(bus.o_q), 32'd5);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("rst_nold", 0, 0, 1, 1);

        // Randomized traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            bit ld;
            bit en;
            bit ar;
            int din;
            ld  = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            ar  = ($urandom_range(0, 1) == 1);
            din = (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)));
            step("rand", ld, din, en, ar);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
